frame_tx_scheduler: RTL and testbench

Sequences transmission of one captured camera frame from the frame RAM to the UART transmitter. It waits for a frame boundary on the camera vertical sync, then freezes the capture writer. It reads the frame RAM byte by byte and hands each byte to the transmitter with a start/done handshake. When the whole frame has been sent it releases the RAM. It sits between the frame RAM read port, the capture block's write enable and the UART Tx block, in the `i_Clk` domain.

---
 rtl/frame_tx_scheduler.sv | 136 +++++++++++++
 tb/tb_frame_tx_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_tx_scheduler.sv
// frame_tx_scheduler
//
// Sends one captured camera frame from the frame RAM to the UART transmitter.
// A rising edge on the camera vertical sync starts a transfer. The capture
// writer stays frozen until every byte has gone out. Each byte is read from
// RAM, registered, and then launched with a single-cycle start pulse. The
// block waits for the transmitter's done pulse before it fetches the next byte.
//
// Ports
//   i_Clk             system clock, rising edge
//   i_Rst_n           synchronous active-low reset
//   i_Enable          lets frame boundaries start transfers
//   i_VS              camera vertical sync (asynchronous)
//   o_Rd_En           RAM read enable
//   o_Rd_Addr         RAM read address
//   i_Rd_Data         RAM read data, valid one cycle after o_Rd_En
//   o_Tx_Data         byte presented to the transmitter
//   o_Tx_Start        one-cycle launch pulse to the transmitter
//   i_Tx_Done         one-cycle completion pulse from the transmitter
//   o_Write_Inhibit   high while a transfer is in progress
//   o_Frame_Sent      one-cycle pulse after the last byte completes
//   o_Frame_Indicator toggles once per sent frame
//   o_Dropped         saturating count of frame boundaries lost to a busy transfer
module frame_tx_scheduler #(
  parameter int BYTES_PER_FRAME = 9216,
  parameter int ADDR_W          = 15
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Enable,
  input  logic              i_VS,
  output logic              o_Rd_En,
  output logic [ADDR_W-1:0] o_Rd_Addr,
  input  logic [7:0]        i_Rd_Data,
  output logic [7:0]        o_Tx_Data,
  output logic              o_Tx_Start,
  input  logic              i_Tx_Done,
  output logic              o_Write_Inhibit,
  output logic              o_Frame_Sent,
  output logic              o_Frame_Indicator,
  output logic [7:0]        o_Dropped
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_READ    = 3'd1;
  localparam logic [2:0] ST_LOAD    = 3'd2;
  localparam logic [2:0] ST_SEND    = 3'd3;
  localparam logic [2:0] ST_WAIT_TX = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(BYTES_PER_FRAME - 1);

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic              vs_meta;
  logic              vs_sync;
  logic              vs_prev;
  logic              vs_rise;
  logic              frame_start;
  logic [ADDR_W-1:0] byte_cnt;

  // Two flops resynchronise the asynchronous sync. The third flop holds the
  // previous synchronised value so that a rising edge can be detected.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the chain into one flop.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      vs_meta <= 1'b0;
      vs_sync <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      vs_meta <= i_VS;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  assign vs_rise     = vs_sync & ~vs_prev;
  assign frame_start = (state == ST_IDLE) && vs_rise && i_Enable;

  // NOTE: the default assignment at the top keeps every path assigned, so no
  // latch is inferred for state_next.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (frame_start) state_next = ST_READ;
      ST_READ:    state_next = ST_LOAD;
      ST_LOAD:    state_next = ST_SEND;
      ST_SEND:    state_next = ST_WAIT_TX;
      ST_WAIT_TX: if (i_Tx_Done) state_next = (byte_cnt == LAST_BYTE) ? ST_DONE : ST_READ;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state             <= ST_IDLE;
      byte_cnt          <= '0;
      o_Tx_Data         <= 8'h00;
      o_Frame_Indicator <= 1'b0;
      o_Dropped         <= 8'h00;
    end else begin
      state <= state_next;

      // The byte counter doubles as the read address. It resets at the
      // start of each frame and stops at the last byte, so it never wraps.
      if (frame_start)
        byte_cnt <= '0;
      else if (state == ST_WAIT_TX && i_Tx_Done && byte_cnt != LAST_BYTE)
        byte_cnt <= byte_cnt + ADDR_W'(1);

      // RAM data arrives one cycle after the read. It is then held through
      // SEND and WAIT_TX.
      if (state == ST_LOAD)
        o_Tx_Data <= i_Rd_Data;

      if (state == ST_DONE)
        o_Frame_Indicator <= ~o_Frame_Indicator;

      // DONE still counts as busy, because a new frame is only accepted
      // once the block is back in IDLE.
      if (vs_rise && i_Enable && state != ST_IDLE && o_Dropped != 8'hFF)
        o_Dropped <= o_Dropped + 8'd1;
    end
  end

  // The outputs below are pure decodes of the state register, so they change
  // only on a clock edge and fall on the first edge after reset.
  assign o_Rd_En         = (state == ST_READ);
  assign o_Rd_Addr       = byte_cnt;
  assign o_Tx_Start      = (state == ST_SEND);
  assign o_Write_Inhibit = (state != ST_IDLE);
  assign o_Frame_Sent    = (state == ST_DONE);

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// Testbench for frame_tx_scheduler with a 4-byte frame, a one-cycle-latency
// RAM model and a transmitter model that answers 10 cycles after each start.
// Expected bytes are queued when a frame is triggered and are compared when
// the DUT issues each start pulse.
module tb_frame_tx_scheduler;

  localparam int BPF = 4;
  localparam int AW  = 15;

  logic          i_Clk = 1'b0;
  logic          i_Rst_n;
  logic          i_Enable;
  logic          i_VS;
  logic          o_Rd_En;
  logic [AW-1:0] o_Rd_Addr;
  logic [7:0]    i_Rd_Data;
  logic [7:0]    o_Tx_Data;
  logic          o_Tx_Start;
  logic          i_Tx_Done;
  logic          o_Write_Inhibit;
  logic          o_Frame_Sent;
  logic          o_Frame_Indicator;
  logic [7:0]    o_Dropped;

  logic model_done;
  logic spur_done;
  logic tx_busy;
  int   tx_timer;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cnt = 0;
  int rd_cnt = 0;
  int sent_cnt = 0;
  int first_rd_cyc = -1;
  int first_rd_addr = -1;
  int first_start_cyc = -1;
  int last_done_cyc = -1;
  int sent_cyc = -1;
  logic prev_start = 1'b0;
  logic sb_on = 1'b1;
  logic [7:0] sb[$];

  frame_tx_scheduler #(.BYTES_PER_FRAME(BPF), .ADDR_W(AW)) dut (
    .i_Clk            (i_Clk),
    .i_Rst_n          (i_Rst_n),
    .i_Enable         (i_Enable),
    .i_VS             (i_VS),
    .o_Rd_En          (o_Rd_En),
    .o_Rd_Addr        (o_Rd_Addr),
    .i_Rd_Data        (i_Rd_Data),
    .o_Tx_Data        (o_Tx_Data),
    .o_Tx_Start       (o_Tx_Start),
    .i_Tx_Done        (i_Tx_Done),
    .o_Write_Inhibit  (o_Write_Inhibit),
    .o_Frame_Sent     (o_Frame_Sent),
    .o_Frame_Indicator(o_Frame_Indicator),
    .o_Dropped        (o_Dropped)
  );

  always #5 i_Clk = ~i_Clk;

  // RAM contents: 0x11, 0x22, 0x33, 0x44.
  function automatic logic [7:0] ram_byte(input int idx);
    return 8'(8'h11 * (idx + 1));
  endfunction

  always @(posedge i_Clk) begin
    if (o_Rd_En) i_Rd_Data <= ram_byte(int'(o_Rd_Addr) % BPF);
  end

  // Transmitter model: done pulse 10 cycles after the start cycle.
  always @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      model_done <= 1'b0;
      tx_busy    <= 1'b0;
      tx_timer   <= 0;
    end else begin
      model_done <= 1'b0;
      if (o_Tx_Start) begin
        tx_busy  <= 1'b1;
        tx_timer <= 9;
      end else if (tx_busy) begin
        if (tx_timer == 1) begin
          tx_busy    <= 1'b0;
          model_done <= 1'b1;
        end else begin
          tx_timer <= tx_timer - 1;
        end
      end
    end
  end

  assign i_Tx_Done = model_done | spur_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: sample outputs at the falling edge and update the monitors.
  task automatic tick();
    @(negedge i_Clk);
    cyc++;
    if (model_done) last_done_cyc = cyc;
    if (o_Rd_En) begin
      rd_cnt++;
      if (first_rd_cyc < 0) begin
        first_rd_cyc  = cyc;
        first_rd_addr = int'(o_Rd_Addr);
      end
      check("rd_addr_range", 32'(int'(o_Rd_Addr) < BPF), 1);
    end
    if (o_Tx_Start) begin
      start_cnt++;
      if (first_start_cyc < 0) first_start_cyc = cyc;
      check("start_not_consecutive", 32'(prev_start), 0);
      if (sb_on) begin
        check("sb_has_entry", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) check("tx_data", 32'(o_Tx_Data), 32'(sb.pop_front()));
      end
    end
    prev_start = o_Tx_Start;
    if (o_Frame_Sent) begin
      sent_cnt++;
      sent_cyc = cyc;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_frame();
    for (int i = 0; i < BPF; i++) sb.push_back(ram_byte(i));
  endtask

  task automatic vs_pulse(input int hi, input int lo);
    i_VS = 1'b1;
    ticks(hi);
    i_VS = 1'b0;
    ticks(lo);
  endtask

  task automatic wait_frame(input int snap);
    int n = 0;
    while (sent_cnt == snap && n < 2000) begin
      tick();
      n++;
    end
    check("frame_sent_seen", 32'(sent_cnt - snap), 1);
  endtask

  task automatic wait_inhibit();
    int n = 0;
    while (!o_Write_Inhibit && n < 20) begin
      tick();
      n++;
    end
    check("transfer_started", 32'(o_Write_Inhibit), 1);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_rd_en"},     32'(o_Rd_En), 0);
    check({pfx, "_rd_addr"},   32'(o_Rd_Addr), 0);
    check({pfx, "_tx_data"},   32'(o_Tx_Data), 0);
    check({pfx, "_tx_start"},  32'(o_Tx_Start), 0);
    check({pfx, "_inhibit"},   32'(o_Write_Inhibit), 0);
    check({pfx, "_sent"},      32'(o_Frame_Sent), 0);
    check({pfx, "_indicator"}, 32'(o_Frame_Indicator), 0);
    check({pfx, "_dropped"},   32'(o_Dropped), 0);
  endtask

  initial begin
    int c0;
    int s_start;
    int s_sent;
    int s_rd;
    int n;
    bit injected;

    i_Rst_n   = 1'b0;
    i_Enable  = 1'b0;
    i_VS      = 1'b0;
    spur_done = 1'b0;

    // Reset state.
    ticks(3);
    check_all_zero("reset");
    i_Rst_n = 1'b1;
    ticks(2);

    // Enable low: sync pulses are ignored and not counted.
    s_rd = rd_cnt;
    for (int i = 0; i < 3; i++) vs_pulse(4, 4);
    ticks(4);
    check("gate_no_read", 32'(rd_cnt - s_rd), 0);
    check("gate_dropped", 32'(o_Dropped), 0);
    check("gate_inhibit", 32'(o_Write_Inhibit), 0);

    // Spurious done in IDLE.
    i_Enable  = 1'b1;
    s_start   = start_cnt;
    s_rd      = rd_cnt;
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    ticks(3);
    check("idle_done_starts", 32'(start_cnt - s_start), 0);
    check("idle_done_reads", 32'(rd_cnt - s_rd), 0);
    check("idle_done_inhibit", 32'(o_Write_Inhibit), 0);

    // Basic frame with latency checks and a spurious done in the first SEND.
    s_start         = start_cnt;
    s_sent          = sent_cnt;
    first_rd_cyc    = -1;
    first_start_cyc = -1;
    push_frame();
    i_VS     = 1'b1;
    c0       = cyc;
    injected = 1'b0;
    n        = 0;
    while (sent_cnt == s_sent && n < 2000) begin
      tick();
      n++;
      spur_done = 1'b0;
      if (o_Tx_Start && !injected) begin
        spur_done = 1'b1;
        injected  = 1'b1;
      end
      if (cyc == c0 + 8) i_VS = 1'b0;
    end
    spur_done = 1'b0;
    check("basic_frame_sent", 32'(sent_cnt - s_sent), 1);
    check("basic_sent_latency", 32'(sent_cyc - last_done_cyc), 1);
    check("basic_inhibit_at_sent", 32'(o_Write_Inhibit), 1);
    tick();
    check("basic_inhibit_low", 32'(o_Write_Inhibit), 0);
    check("basic_indicator", 32'(o_Frame_Indicator), 1);
    check("basic_starts", 32'(start_cnt - s_start), 4);
    check("basic_sb_empty", 32'(sb.size()), 0);
    check("latency_rd", 32'(first_rd_cyc - c0), 3);
    check("latency_rd_addr", 32'(first_rd_addr), 0);
    check("latency_start", 32'(first_start_cyc - c0), 5);
    check("basic_dropped", 32'(o_Dropped), 0);
    ticks(2);

    // Three sync edges while busy are counted and do not disturb the frame.
    s_start = start_cnt;
    s_sent  = sent_cnt;
    push_frame();
    i_VS = 1'b1;
    wait_inhibit();
    i_VS = 1'b0;
    ticks(3);
    for (int i = 0; i < 3; i++) vs_pulse(3, 3);
    wait_frame(s_sent);
    ticks(2);
    check("drop_count", 32'(o_Dropped), 3);
    check("drop_starts", 32'(start_cnt - s_start), 4);
    check("drop_sb_empty", 32'(sb.size()), 0);
    check("drop_indicator", 32'(o_Frame_Indicator), 0);

    // Enable falling mid-frame does not abort the transfer.
    s_start = start_cnt;
    s_sent  = sent_cnt;
    push_frame();
    i_VS = 1'b1;
    wait_inhibit();
    i_VS = 1'b0;
    ticks(10);
    i_Enable = 1'b0;
    wait_frame(s_sent);
    ticks(2);
    check("endrop_starts", 32'(start_cnt - s_start), 4);
    check("endrop_sb_empty", 32'(sb.size()), 0);
    check("endrop_dropped", 32'(o_Dropped), 3);
    check("endrop_indicator", 32'(o_Frame_Indicator), 1);
    i_Enable = 1'b1;

    // Reset during WAIT_TX of the second byte.
    s_start = start_cnt;
    push_frame();
    i_VS = 1'b1;
    wait_inhibit();
    i_VS = 1'b0;
    n = 0;
    while (start_cnt - s_start < 2 && n < 100) begin
      tick();
      n++;
    end
    check("midreset_second_start", 32'(start_cnt - s_start), 2);
    ticks(3);
    check("midreset_busy_before", 32'(o_Write_Inhibit), 1);
    i_Rst_n = 1'b0;
    s_sent  = sent_cnt;
    tick();
    check_all_zero("midreset");
    tick();
    i_Rst_n = 1'b1;
    sb.delete();
    ticks(20);
    check("midreset_no_sent", 32'(sent_cnt - s_sent), 0);
    check("midreset_idle", 32'(o_Write_Inhibit), 0);

    // The first frame after reset restarts at address 0.
    s_start      = start_cnt;
    s_sent       = sent_cnt;
    first_rd_cyc = -1;
    push_frame();
    i_VS = 1'b1;
    wait_inhibit();
    i_VS = 1'b0;
    wait_frame(s_sent);
    ticks(2);
    check("postreset_addr0", 32'(first_rd_addr), 0);
    check("postreset_starts", 32'(start_cnt - s_start), 4);
    check("postreset_sb_empty", 32'(sb.size()), 0);
    check("postreset_indicator", 32'(o_Frame_Indicator), 1);

    // 300 sync edges across busy frames saturate the drop counter.
    sb_on = 1'b0;
    for (int i = 0; i < 300; i++) vs_pulse(2, 2);
    n = 0;
    while (o_Write_Inhibit && n < 200) begin
      tick();
      n++;
    end
    check("sat_idle", 32'(o_Write_Inhibit), 0);
    check("sat_dropped", 32'(o_Dropped), 255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
